// File: rtl/uio_arb_pkg.sv
// Shared types and sizing helpers for the uio pad-bank arbiter.
package uio_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } arb_state_e;

  localparam int PAD_W = 8;

  // Width of an index/counter that must hold values 0..n-1 (never narrower than 1 bit).
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uio_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping modulo N.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [IW:0]    sum;

  assign dbl = {req, req};
  assign rot = dbl[N-1:0] == '0 ? '0 : N'(dbl >> ptr);

  // rot[j] is requester (ptr+j) mod N, so the lowest set bit wins
  always_comb begin
    found = 1'b0;
    idx   = '0;
    sum   = '0;
    for (int j = 0; j < N; j++) begin
      if (!found && rot[j]) begin
        found = 1'b1;
        sum   = {1'b0, ptr} + (IW+1)'(j);
        if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
        idx   = sum[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/uio_bus_arbiter.sv
// Round-robin owner arbitration for the shared 8-bit uio pad bank with forced turnaround.
// Optional owner timeout/preemption is enabled by defining ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no owner, pads released
// GRANT | owner drives uio_out/uio_oe through the lane mux
// TURN  | all pads input for TURN_CYC cycles before the next owner
module uio_bus_arbiter
  import uio_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int TURN_CYC = 1,
  parameter int MAX_HOLD = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*PAD_W-1:0] req_data,
  input  logic [NUM_REQ*PAD_W-1:0] req_oe,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [PAD_W-1:0]         uio_out,
  output logic [PAD_W-1:0]         uio_oe,
  output logic                     busy,
  output logic                     preempt
);

  localparam int IW = idx_w(NUM_REQ);
  localparam int TW = cnt_w(TURN_CYC);

  arb_state_e      state;
  logic [IW-1:0]   owner;
  logic [IW-1:0]   ptr;
  logic [TW-1:0]   turn_cnt;
  logic            pick_found;
  logic [IW-1:0]   pick_idx;
  logic [IW-1:0]   next_ptr;
  logic [NUM_REQ-1:0] pick_onehot;
  logic [PAD_W-1:0] lane_data [NUM_REQ];
  logic [PAD_W-1:0] lane_oe   [NUM_REQ];

`ifdef ARB_TIMEOUT_EN
  localparam int HW = cnt_w(MAX_HOLD);
  logic [HW-1:0] hold_cnt;
  logic          hold_expired;
  assign hold_expired = (hold_cnt == HW'(MAX_HOLD-1)) && ((req & ~gnt) != '0);
`endif

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign lane_data[i] = req_data[i*PAD_W +: PAD_W];
    assign lane_oe[i]   = req_oe[i*PAD_W +: PAD_W];
  end

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req   (req),
    .ptr   (ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign next_ptr    = (owner == IW'(NUM_REQ-1)) ? '0 : owner + 1'b1;
  assign pick_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= '0;
      owner    <= '0;
      ptr      <= '0;
      turn_cnt <= '0;
      busy     <= 1'b0;
      preempt  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      hold_cnt <= '0;
`endif
    end else begin
      preempt <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_found) begin
            state <= GRANT;
            owner <= pick_idx;
            gnt   <= pick_onehot;
            busy  <= 1'b1;
`ifdef ARB_TIMEOUT_EN
            hold_cnt <= '0;
`endif
          end
        end

        GRANT: begin
          if (!req[owner]) begin
            state    <= TURN;
            gnt      <= '0;
            ptr      <= next_ptr;
            turn_cnt <= TW'(TURN_CYC-1);
`ifdef ARB_TIMEOUT_EN
          end else if (hold_expired) begin
            // forced release behaves exactly like a voluntary one, plus the pulse
            state    <= TURN;
            gnt      <= '0;
            ptr      <= next_ptr;
            turn_cnt <= TW'(TURN_CYC-1);
            preempt  <= 1'b1;
          end else if (hold_cnt != HW'(MAX_HOLD-1)) begin
            hold_cnt <= hold_cnt + 1'b1;
`endif
          end
        end

        TURN: begin
          if (turn_cnt != '0) begin
            turn_cnt <= turn_cnt - 1'b1;
          end else if (pick_found) begin
            state <= GRANT;
            owner <= pick_idx;
            gnt   <= pick_onehot;
`ifdef ARB_TIMEOUT_EN
            hold_cnt <= '0;
`endif
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          gnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Pads follow the registered owner only while granted; reset clears state, so pads release at once.
  always_comb begin
    uio_out = '0;
    uio_oe  = '0;
    if (state == GRANT) begin
      uio_out = lane_data[owner];
      uio_oe  = lane_oe[owner];
    end
  end

endmodule
